// File: rtl/tx_frame_mod_if.sv
// Stream bundle between the TX bit source, the framer and the sample sink.
//
// Valid/ready rule on both streams: a transfer happens on a rising clk edge
// where valid && ready. The sender holds its payload stable while valid is
// high and ready is low. The sender never waits for ready before it raises
// valid.
// in_ready is combinational from out_ready and the framer's slot state.
interface tx_frame_mod_if #(
    parameter int DATA_W = 12
) ();
    // Input bit-pair stream and mode select.
    logic                  in_valid;
    logic                  in_i;
    logic                  in_q;
    logic                  in_ready;
    logic                  zero_stuff;

    // Output I/Q sample stream.
    logic                  out_valid;
    logic [2*DATA_W-1:0]   out_data;
    logic                  out_ready;
    logic                  out_last;

    // Source and sink side: drives bits and out_ready, observes samples.
    modport master (
        output in_valid, in_i, in_q, zero_stuff, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    // Framer side.
    modport slave (
        input  in_valid, in_i, in_q, zero_stuff, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/tx_frame_mod.sv
// QPSK transmit framer/modulator.
// Emits frames of HDR_LEN constant header symbols followed by PAYLOAD_LEN
// input symbols. Each symbol is expanded to SPS I/Q samples, either held or
// as an impulse followed by zeros.
module tx_frame_mod #(
    parameter int                   DATA_W      = 12,
    parameter int                   SPS         = 8,
    parameter int                   HDR_LEN     = 16,
    parameter logic [2*HDR_LEN-1:0] HDR_PATTERN = 32'h1ACFFC1D,
    parameter int                   PAYLOAD_LEN = 64,
    parameter int                   AMP         = 1024
) (
    input  logic               clk,
    input  logic               rst,
    tx_frame_mod_if.slave      bus,
    output logic               busy,
    output logic               underrun,
    output logic [1:0]         state_o
);

    localparam int MAX_LEN = (HDR_LEN > PAYLOAD_LEN) ? HDR_LEN : PAYLOAD_LEN;
    // The counter reaches PAYLOAD_LEN (the count of loaded payload symbols).
    localparam int CNT_W   = $clog2(MAX_LEN + 1);
    localparam int S_W     = $clog2(SPS);

    localparam logic [DATA_W-1:0] POS      = DATA_W'(AMP);
    localparam logic [DATA_W-1:0] NEG      = DATA_W'(-AMP);
    localparam logic [S_W-1:0]    LAST_S   = S_W'(SPS - 1);
    localparam logic [CNT_W-1:0]  HDR_LAST = CNT_W'(HDR_LEN - 1);
    localparam logic [CNT_W-1:0]  PAY_LAST = CNT_W'(PAYLOAD_LEN);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2
    } state_t;

    // Bit 0 maps to +AMP and bit 1 maps to -AMP.
    function automatic logic [DATA_W-1:0] map_bit(input logic b);
        return b ? NEG : POS;
    endfunction

    // Sample s of symbol (bi, bq). In zero-stuff mode only s=0 carries energy.
    function automatic logic [2*DATA_W-1:0] sample_val(input logic bi, input logic bq,
                                                       input logic [S_W-1:0] s,
                                                       input logic zs);
        if (zs && (s != '0))
            return '0;
        return {map_bit(bi), map_bit(bq)};
    endfunction

    // Header symbol k as {I, Q} = {bit[2k+1], bit[2k]}.
    function automatic logic [1:0] hdr_sym(input logic [CNT_W-1:0] k);
        logic [1:0] r;
        r = 2'b00;
        for (int j = 0; j < HDR_LEN; j++)
            if (k == CNT_W'(j))
                r = {HDR_PATTERN[2*j+1], HDR_PATTERN[2*j]};
        return r;
    endfunction

    state_t                state_q;
    logic                  zs_q;
    logic                  sym_i_q;
    logic                  sym_q_q;
    logic [S_W-1:0]        s_q;
    // HEADER: index of the current header symbol. PAYLOAD: payload symbols loaded.
    logic [CNT_W-1:0]      cnt_q;
    logic                  out_valid_q;
    logic [2*DATA_W-1:0]   out_data_q;
    logic                  out_last_q;
    logic                  underrun_q;

    logic                  accept;
    logic                  last_samp;
    logic                  next_is_pay;
    logic                  load_opp;
    logic [S_W-1:0]        s_d;
    logic [1:0]            hdr_nxt_d;
    logic [1:0]            hdr0;

    assign accept      = out_valid_q && bus.out_ready;
    assign last_samp   = (s_q == LAST_S);
    assign s_d         = s_q + 1'b1;
    assign hdr_nxt_d   = hdr_sym(cnt_q + 1'b1);
    assign hdr0        = {HDR_PATTERN[1], HDR_PATTERN[0]};
    // The symbol after the current one comes from the input stream.
    assign next_is_pay = ((state_q == HEADER) && (cnt_q == HDR_LAST)) ||
                         ((state_q == PAYLOAD) && (cnt_q < PAY_LAST));
    // A payload pair is taken when the slot is empty or its last sample leaves now.
    assign load_opp    = next_is_pay &&
                         (((state_q == PAYLOAD) && !out_valid_q) || (accept && last_samp));

    assign bus.in_ready  = load_opp;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign busy          = (state_q != IDLE);
    assign underrun      = underrun_q;
    assign state_o       = state_q;

    // Frame FSM: symbol slot, sample counter and registered output sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            zs_q        <= 1'b0;
            sym_i_q     <= 1'b0;
            sym_q_q     <= 1'b0;
            s_q         <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    out_valid_q <= 1'b0;
                    out_last_q  <= 1'b0;
                    // The triggering pair only starts the frame. It is consumed later as payload.
                    if (bus.in_valid) begin
                        state_q     <= HEADER;
                        zs_q        <= bus.zero_stuff;
                        sym_i_q     <= hdr0[1];
                        sym_q_q     <= hdr0[0];
                        s_q         <= '0;
                        cnt_q       <= '0;
                        out_valid_q <= 1'b1;
                        out_data_q  <= sample_val(hdr0[1], hdr0[0], '0, bus.zero_stuff);
                    end
                end

                HEADER: begin
                    if (accept) begin
                        if (!last_samp) begin
                            s_q        <= s_d;
                            out_data_q <= sample_val(sym_i_q, sym_q_q, s_d, zs_q);
                        end else if (cnt_q != HDR_LAST) begin
                            cnt_q      <= cnt_q + 1'b1;
                            s_q        <= '0;
                            sym_i_q    <= hdr_nxt_d[1];
                            sym_q_q    <= hdr_nxt_d[0];
                            out_data_q <= sample_val(hdr_nxt_d[1], hdr_nxt_d[0], '0, zs_q);
                        end else begin
                            state_q <= PAYLOAD;
                            s_q     <= '0;
                            if (bus.in_valid) begin
                                cnt_q      <= CNT_W'(1);
                                sym_i_q    <= bus.in_i;
                                sym_q_q    <= bus.in_q;
                                out_data_q <= sample_val(bus.in_i, bus.in_q, '0, zs_q);
                            end else begin
                                cnt_q       <= '0;
                                out_valid_q <= 1'b0;
                                underrun_q  <= 1'b1;
                            end
                        end
                    end
                end

                PAYLOAD: begin
                    if (!out_valid_q) begin
                        // Starved slot: resume as soon as a pair shows up.
                        if (bus.in_valid) begin
                            cnt_q       <= cnt_q + 1'b1;
                            s_q         <= '0;
                            sym_i_q     <= bus.in_i;
                            sym_q_q     <= bus.in_q;
                            out_valid_q <= 1'b1;
                            out_last_q  <= 1'b0;
                            out_data_q  <= sample_val(bus.in_i, bus.in_q, '0, zs_q);
                        end
                    end else if (accept) begin
                        if (!last_samp) begin
                            s_q        <= s_d;
                            out_data_q <= sample_val(sym_i_q, sym_q_q, s_d, zs_q);
                            out_last_q <= (s_d == LAST_S) && (cnt_q == PAY_LAST);
                        end else if (cnt_q == PAY_LAST) begin
                            state_q     <= IDLE;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                        end else if (bus.in_valid) begin
                            cnt_q      <= cnt_q + 1'b1;
                            s_q        <= '0;
                            sym_i_q    <= bus.in_i;
                            sym_q_q    <= bus.in_q;
                            out_last_q <= 1'b0;
                            out_data_q <= sample_val(bus.in_i, bus.in_q, '0, zs_q);
                        end else begin
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            underrun_q  <= 1'b1;
                        end
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_frame_mod.sv
// Directed bench for tx_frame_mod: DATA_W=12, SPS=4, HDR_LEN=2, HDR_PATTERN=4'b1001,
// PAYLOAD_LEN=3, AMP=1024.
module tb_tx_frame_mod;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       busy;
    logic       underrun;
    logic [1:0] state_o;

    always #5 clk = ~clk;

    tx_frame_mod_if #(.DATA_W(12)) bus ();

    tx_frame_mod #(
        .DATA_W      (12),
        .SPS         (4),
        .HDR_LEN     (2),
        .HDR_PATTERN (4'b1001),
        .PAYLOAD_LEN (3),
        .AMP         (1024)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .busy     (busy),
        .underrun (underrun),
        .state_o  (state_o)
    );

    // ---------------- scoreboard ----------------
    int          pass_cnt  = 0;
    int          fail_cnt  = 0;
    int          total_cnt = 0;
    logic [23:0] exp_q[$];

    // Hand-mapped symbols: header 0, header 1, payload (0,0), (1,1), (0,1).
    logic [23:0] sym_tab[5] = '{24'h400C00, 24'hC00400, 24'h400400, 24'hC00C00, 24'h400C00};
    logic        pi_tab[3]  = '{1'b0, 1'b1, 1'b0};
    logic        pq_tab[3]  = '{1'b0, 1'b1, 1'b1};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic reset_checks(input string pfx);
        check({pfx, "_out_valid"}, 32'(bus.out_valid), 0);
        check({pfx, "_out_data"},  32'(bus.out_data),  0);
        check({pfx, "_out_last"},  32'(bus.out_last),  0);
        check({pfx, "_in_ready"},  32'(bus.in_ready),  0);
        check({pfx, "_busy"},      32'(busy),          0);
        check({pfx, "_underrun"},  32'(underrun),      0);
        check({pfx, "_state"},     32'(state_o),       0);
    endtask

    // ---------------- driver ----------------
    // Runs one frame from IDLE. Called at posedge+1.
    // zs: mode at frame start; bp: random out_ready; gap: cycles to withhold pair 1;
    // abort_at: async reset after this many accepted samples (0 = never);
    // flip_zs: invert zero_stuff after the frame has started.
    task automatic run_frame(input bit zs, input bit bp, input int gap,
                             input int abort_at, input bit flip_zs);
        int          n_acc, pidx, gap_left, first_valid;
        bit          done, saw_gap, stalled;
        logic [23:0] prev_data, exp;
        logic        prev_last;

        exp_q.delete();
        for (int k = 0; k < 5; k++)
            for (int s = 0; s < 4; s++)
                exp_q.push_back((zs && s != 0) ? 24'h000000 : sym_tab[k]);

        n_acc = 0; pidx = 0; gap_left = 0; first_valid = -1;
        done = 0; saw_gap = 0; stalled = 0;
        prev_data = '0; prev_last = 1'b0;

        bus.zero_stuff = zs;
        bus.in_valid   = 1'b1;
        bus.in_i       = pi_tab[0];
        bus.in_q       = pq_tab[0];
        bus.out_ready  = 1'b1;

        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            if (cyc > 0) begin
                if (flip_zs) bus.zero_stuff = ~zs;
                bus.out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
                if (pidx >= 3) begin
                    bus.in_valid = 1'b0;
                end else if (gap_left > 0) begin
                    bus.in_valid = 1'b0;
                    gap_left--;
                end else begin
                    bus.in_valid = 1'b1;
                    bus.in_i     = pi_tab[pidx];
                    bus.in_q     = pq_tab[pidx];
                end
            end
            #1;
            if (bus.out_valid && first_valid < 0) first_valid = cyc;
            if (stalled) begin
                check("stall_data", 32'(bus.out_data), 32'(prev_data));
                check("stall_last", 32'(bus.out_last), 32'(prev_last));
            end
            if (bus.out_valid && !bus.out_ready)
                check("in_ready_while_stalled", 32'(bus.in_ready), 0);
            if (busy && !bus.out_valid) saw_gap = 1;
            if (bus.out_valid && bus.out_ready) begin
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : 24'hxxxxxx;
                n_acc++;
                check($sformatf("sample%0d", n_acc), 32'(bus.out_data), 32'(exp));
                check($sformatf("last%0d", n_acc), 32'(bus.out_last), 32'(n_acc == 20));
                if (n_acc == 20) done = 1;
            end
            stalled   = bus.out_valid && !bus.out_ready;
            prev_data = bus.out_data;
            prev_last = bus.out_last;
            if (bus.in_valid && bus.in_ready) begin
                pidx++;
                if (pidx == 1) gap_left = gap;
            end
            if (abort_at > 0 && n_acc == abort_at) begin
                // Mid-cycle reset: outputs must clear with no clock edge.
                bus.in_valid = 1'b0;
                rst = 1'b1;
                #1;
                reset_checks("midframe_rst");
                @(posedge clk);
                @(negedge clk);
                rst = 1'b0;
                @(posedge clk);
                #1;
                return;
            end
            @(posedge clk);
            #1;
        end

        check("frame_done", 32'(done), 1);
        check("start_latency", 32'(first_valid), 1);
        check("n_samples", 32'(n_acc), 20);
        check("end_busy", 32'(busy), 0);
        check("end_out_valid", 32'(bus.out_valid), 0);
        check("underrun_flag", 32'(underrun), 32'(gap > 0));
        check("gap_seen", 32'(saw_gap), 32'(gap > 0));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bus.in_valid   = 1'b0;
        bus.in_i       = 1'b0;
        bus.in_q       = 1'b0;
        bus.zero_stuff = 1'b0;
        bus.out_ready  = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        reset_checks("initial_rst");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_frame(1'b0, 1'b0, 0, 0, 1'b0);   // hold mode
        run_frame(1'b1, 1'b0, 0, 0, 1'b0);   // zero-stuff mode
        run_frame(1'b0, 1'b1, 0, 0, 1'b1);   // backpressure, mid-frame zero_stuff flip
        run_frame(1'b0, 1'b0, 5, 0, 1'b0);   // payload starvation
        run_frame(1'b0, 1'b0, 0, 10, 1'b0);  // reset mid-payload
        run_frame(1'b0, 1'b0, 0, 0, 1'b0);   // restart after reset

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/tx_frame_mod.md
# tx_frame_mod

Parametrised single-block transmit framer/modulator. It accepts a stream of QPSK bit pairs and emits fixed-length frames of I/Q samples on an AXI-stream style output. Each frame is a constant header followed by PAYLOAD_LEN data symbols, and each symbol is expanded to SPS output samples. It replaces the fixed 12-bit, 8-sample chain of QPSK mapper, header inserter and hold stage on the TX path, and adds configurable width, oversampling, header, frame length and zero-stuff mode.

## Interface
Parameters:
- DATA_W, 12: width of each of I and Q, two's complement.
- SPS, 8: output samples per symbol, ≥2.
- HDR_LEN, 16: header length in symbols, ≥1.
- HDR_PATTERN, 32'h1ACFFC1D: 2*HDR_LEN bits. Header symbol k uses I=bit[2k+1], Q=bit[2k].
- PAYLOAD_LEN, 64: payload symbols per frame, ≥1.
- AMP, 1024: constellation magnitude, 0 < AMP < 2^(DATA_W-1).

Ports:
- clk, in, 1: the single clock.
- rst, in, 1: asynchronous, active-high reset.
- in_valid, in, 1: input bit pair valid.
- in_i, in, 1: I bit.
- in_q, in, 1: Q bit.
- in_ready, out, 1: input handshake. A pair is consumed on in_valid && in_ready.
- zero_stuff, in, 1: mode select. 0 = hold, 1 = impulse plus zeros. Latched at frame start.
- out_valid, out, 1: output sample valid.
- out_data, out, 2*DATA_W: {I, Q}, with I in the upper half.
- out_ready, in, 1: output handshake. A sample is accepted on out_valid && out_ready.
- out_last, out, 1: high on the final sample of a frame.
- busy, out, 1: high whenever a frame is in progress (state ≠ IDLE).
- underrun, out, 1: sticky. Set on a payload starvation; cleared only by rst.

## Operation
Mapping: bit 0 → +AMP, bit 1 → −AMP. Results are sign-extended to DATA_W.

State machine: IDLE → HEADER → PAYLOAD → IDLE.
- IDLE: out_valid=0, in_ready=0. When in_valid=1, latch zero_stuff, load header symbol 0, set sample count to 0, go to HEADER. The triggering input pair is not consumed.
- Symbol slot: holds the current symbol and a sample counter s = 0..SPS-1.
  - The counter advances on each accepted sample.
  - On acceptance at s=SPS-1, the next symbol is loaded in the same cycle, giving a gapless stream.
- HEADER: symbols 0..HDR_LEN-1 come from HDR_PATTERN.
  - When the last header symbol's last sample is accepted, the next symbol is payload 0.
- PAYLOAD: symbols come from the input.
  - A payload symbol loads on a "load opportunity": the slot is empty (out_valid=0), or out_ready && s==SPS-1 with the next symbol being payload.
  - in_ready = load opportunity && next symbol is payload. It is combinational from out_ready and the slot state.
  - If in_valid=0 at a load opportunity where out_valid was 1: set underrun, drop out_valid, keep the payload count. The frame resumes when in_valid rises, loading at the next empty-slot opportunity.
- Sample value:
  - Hold mode: every sample of the symbol equals the mapped symbol.
  - Zero-stuff mode: s=0 carries the mapped symbol; s=1..SPS-1 carry {0,0}.
- out_last = 1 exactly when s==SPS-1 on payload symbol PAYLOAD_LEN-1.
- Frame end: when the out_last sample is accepted, go to IDLE. out_valid=0 for at least one cycle before the next frame.
- Counters: the symbol counter spans max(HDR_LEN, PAYLOAD_LEN). All counters are sized with $clog2 and have no wrap beyond their terminal value.

## Timing
- Reset: out_valid=0, out_data=0, out_last=0, in_ready=0, busy=0, underrun=0, state=IDLE. Reset mid-frame aborts the frame immediately; no partial completion.
- Start latency: in_valid high in IDLE at cycle n gives out_valid=1 with header symbol 0 at cycle n+1.
- Outputs out_data, out_valid and out_last are registered. out_data and out_last hold stable while out_valid && !out_ready.
- Input-to-output latency: a pair accepted at cycle n appears on out_data at cycle n+1.
- Frame length: exactly (HDR_LEN+PAYLOAD_LEN)*SPS accepted samples.
- zero_stuff changes mid-frame have no effect until the next IDLE exit.

## Test plan
Bench parameters: DATA_W=12, SPS=4, HDR_LEN=2, HDR_PATTERN=4'b1001, PAYLOAD_LEN=3, AMP=1024.

- Reset: assert rst asynchronously mid-cycle → all outputs 0 at once, with no clock edge required. Release, then in_valid=1 → out_valid at the next edge.
- Hold frame, out_ready=1, payload pairs (0,0),(1,1),(0,1):
  - Header: 4× 24'h400C00, then 4× 24'hC00400.
  - Payload: 4× 24'h400400, 4× 24'hC00C00, 4× 24'h400C00.
  - out_last only on sample 20. Then busy=0.
- Zero-stuff frame, same stimulus → each symbol is its value followed by 3× 24'h000000. Total 20 samples, out_last on the final zero.
- Backpressure: toggle out_ready randomly → identical sample sequence. out_data stable while stalled. in_ready never high while out_ready=0 and out_valid=1.
- Underrun: withhold the second payload pair for 5 cycles → underrun=1, out_valid=0 during the gap. The frame then completes with the correct 20 samples, and underrun stays 1 after the frame.
- Reset mid-payload, then restart → the new frame begins again with header symbol 0, and underrun=0.
